br_credit_sender_gate: RTL and testbench
========================================

Name: br_credit_sender_gate

Overview:
- Credit-gated sender stage. Sits directly downstream of the producer and upstream of a credit-based link to a receiver.
- Holds a local credit count that drops by one per accepted push and rises by the credits returned from the receiver.
- Blocks the push when no spendable credit remains.
- Registers the payload into a single-cycle pop pulse. The pop side has no backpressure: a credit guarantees space at the receiver.

Parameters:
- Width, 8, payload width in bits (>=1).
- MaxCredit, 8, maximum credits held (>=1). CountWidth = $clog2(MaxCredit+1).
- MaxCreditReturn, 1, maximum credits returned per cycle (>=1, <=MaxCredit). ReturnWidth = $clog2(MaxCreditReturn+1).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- reinit  input  1  reload credit count from initial_credit; single-cycle pulse or level.
- initial_credit  input  CountWidth  credit load value; must be <= MaxCredit; held stable except around reinit.
- credit_withhold  input  CountWidth  credits reserved (not spendable); must be <= MaxCredit.
- push_valid  input  1  producer has data.
- push_ready  output  1  stage accepts data this cycle.
- push_data  input  Width  payload.
- credit_return  input  ReturnWidth  credits returned this cycle; 0 means none; must be <= MaxCreditReturn.
- pop_valid  output  1  registered single-cycle transfer pulse to the link.
- pop_data  output  Width  registered payload; valid only when pop_valid.
- credit_count  output  CountWidth  current credit count (registered).
- credit_available  output  CountWidth  spendable credits: credit_count - credit_withhold if positive, else 0 (combinational).

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM = INIT; credit_count = 0; pop_valid = 0; pop_data = 0.
  - push_ready = 0 while in reset.
- FSM states INIT, ACTIVE:
  - INIT: push_ready = 0. Next posedge loads credit_count <= initial_credit and moves to ACTIVE. credit_return seen in INIT is dropped.
  - ACTIVE with reinit = 1: push_ready = 0. credit_count <= initial_credit. credit_return this cycle is dropped. Stays ACTIVE; a held reinit keeps reloading.
  - ACTIVE with reinit = 0: push_ready = (credit_available != 0) && !reinit. push_ready depends only on registered state and the reinit/withhold inputs, never on push_valid.
- Transfer:
  - push_xfer = push_valid & push_ready.
  - credit_count <= credit_count - push_xfer + credit_return. Compute in CountWidth+1 bits.
- Simultaneous events:
  - Push and return in the same cycle net out, e.g. count 0 + return 1 with no push gives 1.
  - A return arriving with count = 0 does not make push_ready high in the same cycle. Its credit is usable from the next cycle (no combinational return-to-ready path).
- Overflow:
  - A sum above MaxCredit is an illegal receiver behaviour; covered by assertion no_credit_overflow_a.
  - RTL saturates credit_count at MaxCredit.
- Underflow: impossible by construction, since push_ready requires credit_available >= 1. Covered by assertion no_credit_underflow_a.
- Latency:
  - Push accepted at cycle N gives pop_valid = 1 and pop_data = push_data in cycle N+1.
  - pop_valid = 0 in any cycle following a non-transfer cycle. Back-to-back pushes give back-to-back pops.
- Withhold: credit_withhold may change any cycle. Raising it to >= credit_count drops push_ready in the same cycle without changing credit_count.
- Reset mid-operation:
  - Asserting rst_n low clears state immediately, including an in-flight pop_valid.
  - Deassertion always passes through one INIT cycle.
- Assertions:
  - Input assumptions: initial_credit <= MaxCredit; credit_withhold <= MaxCredit; credit_return <= MaxCreditReturn.
  - Output checks: credit_count <= MaxCredit; pop_valid == $past(push_xfer); push_data known when push_valid.
- Covers: credit_count==0 with push_valid; reinit with push_valid; return with push in same cycle; credit_count==MaxCredit.

Test Plan:
- Reset, initial_credit=4, push_valid held high 6 cycles, no return:
  - INIT cycle has push_ready=0.
  - Exactly 4 pops on consecutive cycles 1 cycle after each accept.
  - credit_count 4->0, then push_ready=0.
- count=0, credit_return=1 at cycle N with push_valid high:
  - push_ready=0 at N, 1 at N+1.
  - Push accepted at N+1, pop at N+2, count back to 0.
- count=3, push accepted and credit_return=1 same cycle:
  - count stays 3.
  - With MaxCreditReturn=2, return 2 plus push gives 4.
- count=5, credit_withhold=5:
  - push_ready=0, credit_available=0.
  - Drop withhold to 3: push_ready=1, credit_available=2; two pushes then stall.
- reinit pulse with initial_credit=2 while count=6, push_valid and credit_return=1 high:
  - No transfer that cycle; return dropped; next cycle count=2, push_ready=1.
- rst_n asserted low on the cycle after a push (pop_valid=1):
  - pop_valid and count clear to 0 immediately.
  - After release: one INIT cycle, then count=initial_credit.

Source files
------------

// File: rtl/br_credit_sender_gate.sv
// br_credit_sender_gate: credit-gated sender stage; spends one credit per push, refills from receiver returns
module br_credit_sender_gate #(
    parameter int Width           = 8,
    parameter int MaxCredit       = 8,
    parameter int MaxCreditReturn = 1,
    localparam int CountWidth     = $clog2(MaxCredit + 1),
    localparam int ReturnWidth    = $clog2(MaxCreditReturn + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   reinit,
    input  logic [CountWidth-1:0]  initial_credit,
    input  logic [CountWidth-1:0]  credit_withhold,
    input  logic                   push_valid,
    output logic                   push_ready,
    input  logic [Width-1:0]       push_data,
    input  logic [ReturnWidth-1:0] credit_return,
    output logic                   pop_valid,
    output logic [Width-1:0]       pop_data,
    output logic [CountWidth-1:0]  credit_count,
    output logic [CountWidth-1:0]  credit_available
);
    typedef enum logic {INIT, ACTIVE} state_t;
    localparam logic [CountWidth:0] MaxC = (CountWidth + 1)'(MaxCredit);
    state_t state;
    logic push_xfer;
    logic [CountWidth:0] sum;
    logic [CountWidth-1:0] next_count;
    always_comb begin
        credit_available = credit_count > credit_withhold ? credit_count - credit_withhold : '0;
        push_ready = state == ACTIVE && !reinit && credit_available != '0;
        push_xfer  = push_valid && push_ready;
        sum = {1'b0, credit_count} - (CountWidth + 1)'(push_xfer) + (CountWidth + 1)'(credit_return);
        // an illegal over-return saturates instead of wrapping
        next_count = sum > MaxC ? CountWidth'(MaxCredit) : sum[CountWidth-1:0];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= INIT;
            credit_count <= '0;
            pop_valid    <= 1'b0;
            pop_data     <= '0;
        end else begin
            state     <= ACTIVE;
            pop_valid <= push_xfer;
            if (push_xfer) pop_data <= push_data;
            credit_count <= (state == INIT || reinit) ? initial_credit : next_count;
        end
    end
    initial_credit_a: assert property (@(posedge clk) disable iff (!rst_n) initial_credit <= CountWidth'(MaxCredit));
    withhold_a: assert property (@(posedge clk) disable iff (!rst_n) credit_withhold <= CountWidth'(MaxCredit));
    credit_return_a: assert property (@(posedge clk) disable iff (!rst_n) credit_return <= ReturnWidth'(MaxCreditReturn));
    no_credit_overflow_a: assert property (@(posedge clk) disable iff (!rst_n) (state == ACTIVE && !reinit) |-> sum <= MaxC);
    no_credit_underflow_a: assert property (@(posedge clk) disable iff (!rst_n) push_xfer |-> credit_count != '0);
    count_max_a: assert property (@(posedge clk) disable iff (!rst_n) credit_count <= CountWidth'(MaxCredit));
    pop_pulse_a: assert property (@(posedge clk) disable iff (!rst_n) pop_valid == $past(push_xfer));
    push_data_known_a: assert property (@(posedge clk) disable iff (!rst_n) push_valid |-> !$isunknown(push_data));
    zero_push_c: cover property (@(posedge clk) disable iff (!rst_n) credit_count == '0 && push_valid);
    reinit_push_c: cover property (@(posedge clk) disable iff (!rst_n) reinit && push_valid);
    return_push_c: cover property (@(posedge clk) disable iff (!rst_n) push_xfer && credit_return != '0);
    full_c: cover property (@(posedge clk) disable iff (!rst_n) credit_count == CountWidth'(MaxCredit));
endmodule

// File: tb/tb_br_credit_sender_gate.sv
// tb_br_credit_sender_gate: directed checks of credit gating, pop latency, withhold, reinit and async reset
module tb_br_credit_sender_gate;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       reinit = 1'b0;
    logic [3:0] initial_credit = 4'd4;
    logic [3:0] credit_withhold = 4'd0;
    logic       push_valid = 1'b0;
    logic       push_ready;
    logic [7:0] push_data = 8'h00;
    logic [1:0] credit_return = 2'd0;
    logic       pop_valid;
    logic [7:0] pop_data;
    logic [3:0] credit_count;
    logic [3:0] credit_available;
    int n_checks = 0;
    int n_fail = 0;

    br_credit_sender_gate #(.Width(8), .MaxCredit(8), .MaxCreditReturn(2)) dut (
        .clk(clk), .rst_n(rst_n), .reinit(reinit), .initial_credit(initial_credit),
        .credit_withhold(credit_withhold), .push_valid(push_valid), .push_ready(push_ready),
        .push_data(push_data), .credit_return(credit_return), .pop_valid(pop_valid),
        .pop_data(pop_data), .credit_count(credit_count), .credit_available(credit_available)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] t_cnt [6] = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd0};
        logic       t_pv  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic       t_rdy [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        #1;
        chk("rst_ready", 32'(push_ready), 0);
        chk("rst_count", 32'(credit_count), 0);
        chk("rst_pop", 32'(pop_valid), 0);
        step();
        step();
        // drain four credits with push_valid held high
        rst_n = 1'b1;
        push_valid = 1'b1;
        #1;
        chk("init_ready", 32'(push_ready), 0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("drain_cnt%0d", i), 32'(credit_count), 32'(t_cnt[i]));
            chk($sformatf("drain_pv%0d", i), 32'(pop_valid), 32'(t_pv[i]));
            chk($sformatf("drain_rdy%0d", i), 32'(push_ready), 32'(t_rdy[i]));
            if (t_pv[i]) chk($sformatf("drain_pd%0d", i), 32'(pop_data), 32'(8'hA0 + i - 1));
            push_data = 8'(8'hA0 + i);
        end
        // return at zero credits is usable only from the next cycle
        credit_return = 2'd1;
        push_data = 8'h5A;
        #1;
        chk("ret0_ready_n", 32'(push_ready), 0);
        step();
        credit_return = 2'd0;
        chk("ret0_ready_n1", 32'(push_ready), 1);
        chk("ret0_cnt_n1", 32'(credit_count), 1);
        step();
        chk("ret0_pv", 32'(pop_valid), 1);
        chk("ret0_pd", 32'(pop_data), 32'h5A);
        chk("ret0_cnt", 32'(credit_count), 0);
        push_valid = 1'b0;
        initial_credit = 4'd3;
        reinit = 1'b1;
        step();
        reinit = 1'b0;
        chk("reload3", 32'(credit_count), 3);
        push_valid = 1'b1;
        credit_return = 2'd1;
        step();
        chk("net_cnt3", 32'(credit_count), 3);
        chk("net_pv", 32'(pop_valid), 1);
        credit_return = 2'd2;
        step();
        chk("net_cnt4", 32'(credit_count), 4);
        push_valid = 1'b0;
        credit_return = 2'd1;
        step();
        credit_return = 2'd0;
        chk("cnt5", 32'(credit_count), 5);
        credit_withhold = 4'd5;
        #1;
        chk("wh5_ready", 32'(push_ready), 0);
        chk("wh5_avail", 32'(credit_available), 0);
        credit_withhold = 4'd3;
        #1;
        chk("wh3_ready", 32'(push_ready), 1);
        chk("wh3_avail", 32'(credit_available), 2);
        push_valid = 1'b1;
        step();
        chk("wh_cnt4", 32'(credit_count), 4);
        chk("wh_avail1", 32'(credit_available), 1);
        step();
        chk("wh_cnt3", 32'(credit_count), 3);
        chk("wh_stall", 32'(push_ready), 0);
        chk("wh_pv", 32'(pop_valid), 1);
        step();
        chk("wh_cnt_hold", 32'(credit_count), 3);
        chk("wh_pv_off", 32'(pop_valid), 0);
        push_valid = 1'b0;
        credit_withhold = 4'd0;
        credit_return = 2'd2;
        step();
        credit_return = 2'd1;
        step();
        chk("cnt6", 32'(credit_count), 6);
        // reinit blocks the push and drops the return
        reinit = 1'b1;
        initial_credit = 4'd2;
        push_valid = 1'b1;
        #1;
        chk("reinit_ready", 32'(push_ready), 0);
        step();
        reinit = 1'b0;
        credit_return = 2'd0;
        #1;
        chk("reinit_cnt", 32'(credit_count), 2);
        chk("reinit_pv", 32'(pop_valid), 0);
        chk("reinit_ready1", 32'(push_ready), 1);
        initial_credit = 4'd4;
        step();
        push_valid = 1'b0;
        chk("pre_rst_pv", 32'(pop_valid), 1);
        chk("pre_rst_cnt", 32'(credit_count), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pv", 32'(pop_valid), 0);
        chk("mid_rst_cnt", 32'(credit_count), 0);
        chk("mid_rst_ready", 32'(push_ready), 0);
        step();
        rst_n = 1'b1;
        #1;
        chk("post_rst_init", 32'(push_ready), 0);
        chk("post_rst_cnt0", 32'(credit_count), 0);
        step();
        chk("post_rst_cnt", 32'(credit_count), 4);
        chk("post_rst_ready", 32'(push_ready), 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
